// File: rtl/muldiv_unit_if.sv
// Operand/launch and write-back bundle between the issue stage, the
// multiply/divide unit and the register-file write port.
interface muldiv_unit_if;
   logic        start_i;
   logic [2:0]  op_i;
   logic [31:0] rs1_data_i;
   logic [31:0] rs2_data_i;
   logic [4:0]  rd_addr_i;
   logic        flush_i;
   logic        busy_o;
   logic [4:0]  reg_waddr;
   logic [31:0] reg_wdata;
   logic        reg_wen;

   // Issue side: launches operations and observes write-back
   modport master (
      output start_i, op_i, rs1_data_i, rs2_data_i, rd_addr_i, flush_i,
      input  busy_o, reg_waddr, reg_wdata, reg_wen
   );

   // Execution unit side
   modport slave (
      input  start_i, op_i, rs1_data_i, rs2_data_i, rd_addr_i, flush_i,
      output busy_o, reg_waddr, reg_wdata, reg_wen
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit. Operands are reduced to magnitudes
// at launch, one shift-add or restoring-divide step runs per cycle for
// XLEN cycles, and the signed result is written back in a single DONE cycle.
// Divide-by-zero and signed overflow are resolved in the launch cycle.
module muldiv_unit #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 5
) (
   input  logic         sys_clk,
   input  logic         sys_rst_n,
   muldiv_unit_if.slave bus
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [XLEN-1:0] XMIN = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [2:0]        op_q, op_d;
   logic [4:0]        rd_q, rd_d;
   logic [XLEN-1:0]   opnd_q, opnd_d;   // multiplicand (MUL*) or divisor (DIV*/REM*)
   logic [2*XLEN-1:0] acc_q, acc_d;     // MUL*: {partial hi, multiplier}; DIV*: {remainder, dividend/quotient}
   logic              neg_q, neg_d;     // product/quotient sign
   logic              rneg_q, rneg_d;   // remainder sign
   logic [XLEN-1:0]   res_q, res_d;

   logic              launch;
   logic              sa_in, sb_in;
   logic [XLEN-1:0]   a_mag, b_mag;
   logic              div_zero, div_ovf;
   logic [XLEN:0]     mul_sum;
   logic [2*XLEN-1:0] mul_next;
   logic [2*XLEN:0]   div_shift;
   logic [XLEN:0]     div_diff;
   logic [2*XLEN-1:0] div_next;
   logic [2*XLEN-1:0] step;
   logic [2*XLEN-1:0] prod_signed;
   logic [XLEN-1:0]   res_fin;

   assign launch = (state_q == S_IDLE) && bus.start_i && !bus.flush_i;

   // Which operands are interpreted as signed for the incoming op
   always_comb begin
      sa_in = 1'b0;
      sb_in = 1'b0;
      case (bus.op_i)
         3'b001:         begin sa_in = bus.rs1_data_i[XLEN-1]; sb_in = bus.rs2_data_i[XLEN-1]; end
         3'b010:         sa_in = bus.rs1_data_i[XLEN-1];
         3'b100, 3'b110: begin sa_in = bus.rs1_data_i[XLEN-1]; sb_in = bus.rs2_data_i[XLEN-1]; end
         default:        ;
      endcase
   end

   assign a_mag    = sa_in ? (-bus.rs1_data_i) : bus.rs1_data_i;
   assign b_mag    = sb_in ? (-bus.rs2_data_i) : bus.rs2_data_i;
   assign div_zero = (bus.rs2_data_i == '0);
   assign div_ovf  = !bus.op_i[0] && (bus.rs1_data_i == XMIN) && (bus.rs2_data_i == '1);

   // One shift-add step: add multiplicand into the high half when the
   // multiplier LSB is set, then shift the whole accumulator right.
   assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? opnd_q : '0)};
   assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

   // One restoring-divide step: shift the next dividend bit into the
   // remainder, keep the subtraction only when it does not borrow.
   assign div_shift = {acc_q, 1'b0};
   assign div_diff  = div_shift[2*XLEN:XLEN] - {1'b0, opnd_q};
   assign div_next  = div_diff[XLEN] ? div_shift[2*XLEN-1:0]
                                     : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

   assign step        = op_q[2] ? div_next : mul_next;
   assign prod_signed = neg_q ? (-step) : step;

   // Final sign fix-up and result selection after the last iteration
   always_comb begin
      res_fin = '0;
      case (op_q)
         3'b000:                 res_fin = prod_signed[XLEN-1:0];
         3'b001, 3'b010, 3'b011: res_fin = prod_signed[2*XLEN-1:XLEN];
         3'b100, 3'b101:         res_fin = neg_q  ? (-step[XLEN-1:0])      : step[XLEN-1:0];
         default:                res_fin = rneg_q ? (-step[2*XLEN-1:XLEN]) : step[2*XLEN-1:XLEN];
      endcase
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      op_d    = op_q;
      rd_d    = rd_q;
      opnd_d  = opnd_q;
      acc_d   = acc_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      res_d   = res_q;
      case (state_q)
         S_IDLE: begin
            if (launch) begin
               op_d   = bus.op_i;
               rd_d   = bus.rd_addr_i;
               neg_d  = sa_in ^ sb_in;
               rneg_d = sa_in;
               cnt_d  = '0;
               if (bus.op_i[2] && div_zero) begin
                  res_d   = bus.op_i[1] ? bus.rs1_data_i : '1;
                  state_d = S_DONE;
               end else if (bus.op_i[2] && div_ovf) begin
                  res_d   = bus.op_i[1] ? '0 : XMIN;
                  state_d = S_DONE;
               end else begin
                  opnd_d  = bus.op_i[2] ? b_mag : a_mag;
                  acc_d   = {{XLEN{1'b0}}, (bus.op_i[2] ? a_mag : b_mag)};
                  state_d = S_CALC;
               end
            end
         end
         S_CALC: begin
            if (bus.flush_i) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               acc_d = step;
               if (cnt_q == CNT_LAST) begin
                  res_d   = res_fin;
                  cnt_d   = '0;
                  state_d = S_DONE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers
   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         op_q    <= '0;
         rd_q    <= '0;
         opnd_q  <= '0;
         acc_q   <= '0;
         neg_q   <= 1'b0;
         rneg_q  <= 1'b0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         op_q    <= op_d;
         rd_q    <= rd_d;
         opnd_q  <= opnd_d;
         acc_q   <= acc_d;
         neg_q   <= neg_d;
         rneg_q  <= rneg_d;
         res_q   <= res_d;
      end
   end

   // Write-back is driven only while in DONE; x0 is never written
   assign bus.busy_o    = (state_q != S_IDLE);
   assign bus.reg_wen   = (state_q == S_DONE) && (rd_q != 5'd0);
   assign bus.reg_waddr = (state_q == S_DONE) ? rd_q  : 5'd0;
   assign bus.reg_wdata = (state_q == S_DONE) ? res_q : '0;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed corner cases followed by random ops.
// The driver pushes expected write-backs into a queue; a monitor pops and
// compares on every reg_wen.
module tb_muldiv_unit;

   logic sys_clk   = 1'b0;
   logic sys_rst_n = 1'b0;

   muldiv_unit_if mif ();

   muldiv_unit #(.XLEN(32), .CNT_W(5)) dut (
      .sys_clk   (sys_clk),
      .sys_rst_n (sys_rst_n),
      .bus       (mif)
   );

   always #5 sys_clk = ~sys_clk;

   int cyc = 0;
   always @(posedge sys_clk) cyc++;

   typedef struct {
      logic [4:0]  addr;
      logic [31:0] data;
      int          cyc;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, req);
      end
   endtask

   // Behavioural reference: plain 64-bit and signed/unsigned SV arithmetic
   function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] x, y, p;
      int ia, ib;
      ia = a;
      ib = b;
      if (!op[2]) begin
         x = (op == 3'b001 || op == 3'b010) ? {{32{a[31]}}, a} : {32'd0, a};
         y = (op == 3'b001)                 ? {{32{b[31]}}, b} : {32'd0, b};
         p = x * y;
         return (op == 3'b000) ? p[31:0] : p[63:32];
      end
      if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
      if (!op[0]) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return op[1] ? 32'd0 : a;
         return op[1] ? 32'(ia % ib) : 32'(ia / ib);
      end
      return op[1] ? (a % b) : (a / b);
   endfunction

   function automatic bit is_special(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      if (!op[2]) return 1'b0;
      if (b == 32'd0) return 1'b1;
      return !op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
   endfunction

   // Monitor: every write-back must match the head of the scoreboard
   always @(negedge sys_clk) begin
      if (mif.reg_wen) begin
         if (sb_q.size() == 0) begin
            chk("unexpected_wb", {27'd0, mif.reg_waddr, mif.reg_wdata}, 64'd0);
         end else begin
            exp_t e;
            e = sb_q.pop_front();
            $display("WB cyc=%0d addr=%0d data=%08h (req addr=%0d data=%08h cyc=%0d)",
                     cyc, mif.reg_waddr, mif.reg_wdata, e.addr, e.data, e.cyc);
            chk("wb_addr", 64'(mif.reg_waddr), 64'(e.addr));
            chk("wb_data", 64'(mif.reg_wdata), 64'(e.data));
            chk("wb_cycle", 64'(cyc), 64'(e.cyc));
         end
      end
      if (!mif.busy_o)
         chk("idle_outputs_zero", {26'd0, mif.reg_wen, mif.reg_waddr, mif.reg_wdata}, 64'd0);
   end

   // Drive a launch at the current falling edge; returns at the next one
   task automatic launch(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit expect_wb, output bit special);
      exp_t e;
      special = is_special(op, a, b);
      mif.start_i    = 1'b1;
      mif.flush_i    = 1'b0;
      mif.op_i       = op;
      mif.rs1_data_i = a;
      mif.rs2_data_i = b;
      mif.rd_addr_i  = rd;
      if (expect_wb && rd != 5'd0) begin
         e.addr = rd;
         e.data = ref_model(op, a, b);
         e.cyc  = cyc + (special ? 1 : 33);
         sb_q.push_back(e);
      end
      @(negedge sys_clk);
      mif.start_i = 1'b0;
      chk("busy_after_launch", 64'(mif.busy_o), 64'd1);
   endtask

   // Count busy cycles while hammering start_i with junk, which must be ignored
   task automatic wait_idle(input int exp_n);
      int n;
      n = 0;
      while (mif.busy_o && n < 60) begin
         n++;
         mif.start_i    = 1'b1;
         mif.op_i       = 3'($urandom_range(0, 7));
         mif.rs1_data_i = $urandom;
         mif.rs2_data_i = $urandom;
         mif.rd_addr_i  = 5'($urandom_range(1, 31));
         @(negedge sys_clk);
      end
      mif.start_i = 1'b0;
      chk("busy_cycles", 64'(n), 64'(exp_n));
   endtask

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
      bit sp;
      launch(op, a, b, rd, 1'b1, sp);
      wait_idle(sp ? 1 : 33);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 6))
         0:       return 32'd0;
         1:       return 32'd1;
         2:       return 32'hFFFF_FFFF;
         3:       return 32'h8000_0000;
         4:       return 32'h7FFF_FFFF;
         5:       return 32'($urandom_range(0, 300));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bit sp;
      mif.start_i    = 1'b0;
      mif.flush_i    = 1'b0;
      mif.op_i       = 3'd0;
      mif.rs1_data_i = 32'd0;
      mif.rs2_data_i = 32'd0;
      mif.rd_addr_i  = 5'd0;

      repeat (3) @(negedge sys_clk);
      chk("reset_outputs", {26'd0, mif.busy_o, mif.reg_wen, mif.reg_waddr, mif.reg_wdata}, 64'd0);
      sys_rst_n = 1'b1;
      @(negedge sys_clk);

      // Directed arithmetic
      run_op(3'b000, 32'd7, 32'hFFFF_FFFD, 5'd5);
      run_op(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6);
      run_op(3'b010, 32'h8000_0000, 32'h8000_0000, 5'd7);
      run_op(3'b011, 32'h8000_0000, 32'h8000_0000, 5'd8);
      run_op(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd9);
      run_op(3'b110, 32'hFFFF_FFF9, 32'd2, 5'd10);
      run_op(3'b101, 32'd100, 32'd7, 5'd11);
      run_op(3'b111, 32'd100, 32'd7, 5'd12);
      // Special cases resolved at launch
      run_op(3'b100, 32'h1234_5678, 32'd0, 5'd13);
      run_op(3'b111, 32'd5, 32'd0, 5'd14);
      run_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd15);
      run_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd16);

      // Flush at counter 10: no write-back, idle next cycle, next op accepted
      launch(3'b000, 32'd123, 32'd456, 5'd20, 1'b0, sp);
      repeat (10) @(negedge sys_clk);
      mif.flush_i = 1'b1;
      @(negedge sys_clk);
      mif.flush_i = 1'b0;
      chk("busy_after_flush", 64'(mif.busy_o), 64'd0);
      run_op(3'b101, 32'd1000, 32'd9, 5'd21);

      // Flush together with start in IDLE launches nothing
      mif.start_i   = 1'b1;
      mif.flush_i   = 1'b1;
      mif.op_i      = 3'b000;
      mif.rd_addr_i = 5'd22;
      @(negedge sys_clk);
      mif.start_i = 1'b0;
      mif.flush_i = 1'b0;
      chk("busy_flush_start", 64'(mif.busy_o), 64'd0);

      // Flush during DONE still commits the write
      launch(3'b101, 32'd77, 32'd0, 5'd23, 1'b1, sp);
      mif.flush_i = 1'b1;
      @(negedge sys_clk);
      mif.flush_i = 1'b0;
      chk("busy_after_done_flush", 64'(mif.busy_o), 64'd0);

      // rd=0: same busy profile, never a write strobe
      run_op(3'b011, 32'hDEAD_BEEF, 32'h1234_5678, 5'd0);

      // Asynchronous reset mid-calculation
      launch(3'b110, 32'hFFFF_0000, 32'd17, 5'd24, 1'b0, sp);
      repeat (20) @(negedge sys_clk);
      @(posedge sys_clk);
      #2 sys_rst_n = 1'b0;
      #1 chk("async_reset_outputs", {26'd0, mif.busy_o, mif.reg_wen, mif.reg_waddr, mif.reg_wdata}, 64'd0);
      @(negedge sys_clk);
      sys_rst_n = 1'b1;
      @(negedge sys_clk);
      run_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd25);

      // Random operations, back-to-back or with short gaps
      for (int i = 0; i < 60; i++) begin
         run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(), 5'($urandom_range(0, 31)));
         repeat ($urandom_range(0, 2)) @(negedge sys_clk);
      end

      repeat (3) @(negedge sys_clk);
      chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
